data_mem_responder: RTL and testbench

- Responder end of the core's data-cache request/valid interface; sits on the memory side of the data port.
- Accepts one load/store request at a time from the core's load/store unit.
- Performs the access on an internal word-organised RAM with per-byte write enables.
- Returns completion through a single-cycle data_valid pulse after a fixed, parameterised latency.

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Memory-side responder for the core's data-cache request/valid port. It takes
// one load or store at a time, runs it against an internal word-organised RAM
// with per-byte write enables, and reports completion with a one-cycle
// data_valid pulse a fixed LATENCY edges after the request was accepted.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   data_req     request from the core, held with stable fields until data_valid
//   data_we      1 = store, 0 = load (sampled at accept)
//   byte_enable  store lane mask, lane i covers wdata[8i+7:8i]
//   data_addr    byte address; [1:0] ignored, word index is [DEPTH_LOG2+1:2]
//   wdata        store data
//   data_valid   one-cycle completion pulse
//   rdata        response word, held until the next response
module data_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_req,
    input  logic                       data_we,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]                 state_reg;
    logic [3:0]                 counter_reg;

    logic                       cap_we_reg;
    logic [BYTE_DATA_WIDTH-1:0] cap_be_reg;
    logic [DEPTH_LOG2-1:0]      cap_idx_reg;
    logic                       cap_in_range_reg;
    logic [DATA_WIDTH-1:0]      cap_wdata_reg;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [DATA_WIDTH-1:0]      read_word_reg;
    logic [DATA_WIDTH-1:0]      merged_word;

    logic                       accept;
    logic                       complete;
    logic                       wr_en;
    logic [DEPTH_LOG2-1:0]      req_idx;
    logic                       req_in_range;

    // A request is taken from IDLE, or straight out of RESP when data_req is
    // still high (back-to-back without an idle cycle).
    assign accept       = data_req && ((state_reg == IDLE) || (state_reg == RESP));
    assign complete     = (state_reg == WAIT) && (counter_reg == 4'd0);
    assign wr_en        = complete && cap_we_reg && cap_in_range_reg;
    assign req_idx      = data_addr[DEPTH_LOG2+1:2];
    // Any set bit above the word index means the address is outside the RAM.
    assign req_in_range = ((data_addr >> (DEPTH_LOG2 + 2)) == '0);

    // Post-write view of the word: enabled lanes from the store data, the
    // rest from the word read at accept time.
    generate
        for (genvar gi = 0; gi < BYTE_DATA_WIDTH; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = cap_be_reg[gi] ? cap_wdata_reg[8*gi +: 8]
                                                           : read_word_reg[8*gi +: 8];
        end
    endgenerate

    // RAM with registered read and byte-lane writes. The read is launched on
    // the accept edge: nothing else writes the RAM while a request is in
    // flight, so the word is still current at the completion edge. Writes only
    // happen from WAIT, so a reset that returns the FSM to IDLE before the
    // completion edge keeps an abandoned store out of the array.
    always_ff @(posedge clk) begin
        if (accept) begin
            read_word_reg <= mem[req_idx];
        end
        if (wr_en) begin
            for (int i = 0; i < BYTE_DATA_WIDTH; i++) begin
                if (cap_be_reg[i]) begin
                    mem[cap_idx_reg][8*i +: 8] <= cap_wdata_reg[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            counter_reg      <= 4'd0;
            data_valid       <= 1'b0;
            rdata            <= '0;
            cap_we_reg       <= 1'b0;
            cap_be_reg       <= '0;
            cap_idx_reg      <= '0;
            cap_in_range_reg <= 1'b0;
            cap_wdata_reg    <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state_reg)
                IDLE, RESP: begin
                    if (accept) begin
                        state_reg        <= WAIT;
                        counter_reg      <= 4'(LATENCY - 1);
                        cap_we_reg       <= data_we;
                        cap_be_reg       <= byte_enable;
                        cap_idx_reg      <= req_idx;
                        cap_in_range_reg <= req_in_range;
                        cap_wdata_reg    <= wdata;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (counter_reg != 4'd0) begin
                        counter_reg <= counter_reg - 4'd1;
                    end else begin
                        state_reg  <= RESP;
                        data_valid <= 1'b1;
                        if (!cap_in_range_reg) begin
                            rdata <= '0;
                        end else if (cap_we_reg) begin
                            rdata <= merged_word;
                        end else begin
                            rdata <= read_word_reg;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (default parameters, LATENCY=2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req;
    logic        data_we;
    logic [3:0]  byte_enable;
    logic [31:0] data_addr;
    logic [31:0] wdata;
    logic        data_valid;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DATA_WIDTH(32),
        .BYTE_DATA_WIDTH(4),
        .DEPTH_LOG2(10),
        .LATENCY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_req(data_req),
        .data_we(data_we),
        .byte_enable(byte_enable),
        .data_addr(data_addr),
        .wdata(wdata),
        .data_valid(data_valid),
        .rdata(rdata)
    );

    // Issues one request and waits (bounded) for data_valid. Returns the
    // response word and the number of edges from accept to completion.
    // Leaves the bench at the falling edge inside the RESP cycle.
    task automatic do_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output int lat);
        int edges;
        @(negedge clk);
        data_req    = 1'b1;
        data_we     = we;
        byte_enable = be;
        data_addr   = addr;
        wdata       = wd;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!data_valid && edges < 50);
        lat = edges - 1;
        rd  = rdata;
        data_req    = 1'b0;
        data_we     = 1'b0;
        byte_enable = 4'h0;
        data_addr   = 32'h0;
        wdata       = 32'h0;
        $display("txn we=%0d be=%h addr=%h wdata=%h -> rdata=%h latency=%0d",
                 we, be, addr, wd, rd, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", data_valid);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (data_valid !== 1'b0 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: got valid=%b rdata=%h expected valid=0 rdata=00000000",
                         i, data_valid, rdata);
            end
        end
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        int lat;
        do_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL store_latency: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_resp: got %h expected deadbeef", rd);
        end
        @(negedge clk);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got valid=%b expected 0", data_valid);
        end
        do_access(1'b0, 4'h0, 32'h10, 32'h0, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL load_latency: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_data: got %h expected deadbeef", rd);
        end
        // Address bits [1:0] are ignored.
        do_access(1'b0, 4'h0, 32'h13, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned_load: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd;
        int lat;
        do_access(1'b1, 4'hF, 32'h20, 32'h11223344, rd, lat);
        do_access(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL partial_store_resp: got %h expected 11bb33dd", rd);
        end
        do_access(1'b0, 4'h0, 32'h20, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL partial_store_load: got %h expected 11bb33dd", rd);
        end
        // Store with no lanes enabled: RAM untouched, response is the current word.
        do_access(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, lat);
        checks++;
        if (lat !== 2 || rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL empty_store_resp: got lat=%0d rdata=%h expected lat=2 rdata=11bb33dd", lat, rd);
        end
        do_access(1'b0, 4'hF, 32'h20, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL empty_store_load: got %h expected 11bb33dd", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic [31:0] r1;
        logic [31:0] r2;
        int lat;
        int e;
        int first_e;
        int second_e;
        do_access(1'b1, 4'hF, 32'h14, 32'h55667788, rd, lat);
        @(negedge clk);
        data_req    = 1'b1;
        data_we     = 1'b0;
        byte_enable = 4'h0;
        data_addr   = 32'h10;
        wdata       = 32'h0;
        e = 0;
        first_e = -1;
        second_e = -1;
        r1 = 32'h0;
        r2 = 32'h0;
        while (second_e < 0 && e < 40) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (data_valid) begin
                if (first_e < 0) begin
                    first_e = e;
                    r1 = rdata;
                    data_addr = 32'h14;
                end else begin
                    second_e = e;
                    r2 = rdata;
                    data_req = 1'b0;
                end
            end
        end
        data_req  = 1'b0;
        data_addr = 32'h0;
        $display("txn back_to_back valid edges %0d and %0d, rdata %h then %h", first_e, second_e, r1, r2);
        checks++;
        if (first_e !== 3) begin
            errors++;
            $display("FAIL b2b_first_edge: got %0d expected 3", first_e);
        end
        checks++;
        if (second_e - first_e !== 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected 3", second_e - first_e);
        end
        checks++;
        if (r1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b_first_data: got %h expected deadbeef", r1);
        end
        checks++;
        if (r2 !== 32'h55667788) begin
            errors++;
            $display("FAIL b2b_second_data: got %h expected 55667788", r2);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd;
        int lat;
        do_access(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, lat);
        do_access(1'b1, 4'hF, 32'h0001_0000, 32'h99999999, rd, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL oor_store_latency: got %0d expected 2", lat);
        end
        do_access(1'b0, 4'h0, 32'h0001_0000, 32'h0, rd, lat);
        checks++;
        if (lat !== 2 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_load: got lat=%0d rdata=%h expected lat=2 rdata=00000000", lat, rd);
        end
        do_access(1'b0, 4'h0, 32'h0, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL oor_word0_intact: got %h expected cafef00d", rd);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] rd;
        int lat;
        do_access(1'b1, 4'hF, 32'h40, 32'hA5A5A5A5, rd, lat);
        @(negedge clk);
        data_req    = 1'b1;
        data_we     = 1'b1;
        byte_enable = 4'hF;
        data_addr   = 32'h40;
        wdata       = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (data_valid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b rdata=%h expected valid=0 rdata=00000000", data_valid, rdata);
        end
        @(negedge clk);
        rst         = 1'b0;
        data_req    = 1'b0;
        data_we     = 1'b0;
        byte_enable = 4'h0;
        data_addr   = 32'h0;
        wdata       = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (data_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_after_reset cycle %0d: got %b expected 0", i, data_valid);
            end
        end
        do_access(1'b0, 4'h0, 32'h40, 32'h0, rd, lat);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL abandoned_store: got %h expected a5a5a5a5", rd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        data_req    = 1'b0;
        data_we     = 1'b0;
        byte_enable = 4'h0;
        data_addr   = 32'h0;
        wdata       = 32'h0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
